// File: rtl/uart_tx.sv
// uart_tx: serialises one DATA_BITS-wide word per request into a UART frame
// (one start bit, DATA_BITS data bits MSB first, one stop bit) on TXD.
// Bit timing comes from the TXC oversampling tick: every bit lasts OVERSAMPLE
// ticks. The frame shifts MSB first, so it matches the companion RX block.
// Every output is registered, so TXD changes only on a clk edge or on rst.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 TXC,
  input  logic                 TX_START,
  input  logic [DATA_BITS-1:0] DQ,
  output logic                 TXD,
  output logic                 TX_BUSY,
  output logic                 TX_END
);

  // Counter widths. The guards keep each width at one bit or more for
  // degenerate parameter values.
  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS > 1)  ? $clog2(DATA_BITS)  : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Registered state and outputs.
  state_t                r_state;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_txd;
  logic                  r_busy;
  logic                  r_end;

  // Next-state values.
  state_t                w_state_next;
  logic [TICK_W-1:0]     w_tick_next;
  logic [BIT_W-1:0]      w_bit_next;
  logic [DATA_BITS-1:0]  w_shift_next;
  logic                  w_txd_next;
  logic                  w_busy_next;
  logic                  w_end_next;
  logic                  w_period_end;

  // A bit period ends on the TXC tick that finds the counter at its last value.
  // The counter never runs in IDLE, so a tick in the acceptance cycle is not
  // counted.
  assign w_period_end = TXC && (r_tick_cnt == TICK_LAST) && (r_state != S_IDLE);

  // Next-state logic: frame sequencing, tick and bit counting, data shifting.
  always_comb begin
    // NOTE: each signal gets a default before the case statement. A path
    // that leaves a signal unassigned would infer a latch.
    w_state_next = r_state;
    w_tick_next  = r_tick_cnt;
    w_bit_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_end_next   = 1'b0;

    if ((r_state != S_IDLE) && TXC) begin
      w_tick_next = w_period_end ? '0 : r_tick_cnt + 1'b1;
    end

    unique case (r_state)
      S_IDLE: begin
        if (TX_START) begin
          w_shift_next = DQ;
          w_tick_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_period_end) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_period_end) begin
          w_shift_next = r_shift << 1;
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_next   = '0;
            w_state_next = S_STOP;
          end else begin
            w_bit_next = r_bit_cnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (w_period_end) begin
          w_state_next = S_IDLE;
          w_end_next   = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state. Registering these values lets TXD and
  // TX_BUSY change in the same cycle the state changes.
  always_comb begin
    w_txd_next = 1'b1;
    unique case (w_state_next)
      S_IDLE:  w_txd_next = 1'b1;
      S_START: w_txd_next = 1'b0;
      S_DATA:  w_txd_next = w_shift_next[DATA_BITS-1];
      S_STOP:  w_txd_next = 1'b1;
      default: w_txd_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  // State and output registers. Reset is asynchronous, so TXD returns to idle
  // at once and any frame in flight is dropped without a TX_END pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      // NOTE: the shift register is cleared on reset along with the control
      // state, so no X can reach TXD from a datapath register that was never
      // loaded.
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_end      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the values
      // from before this edge, whatever the statement order.
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_next;
      r_bit_cnt  <= w_bit_next;
      r_shift    <= w_shift_next;
      r_txd      <= w_txd_next;
      r_busy     <= w_busy_next;
      r_end      <= w_end_next;
    end
  end

  assign TXD     = r_txd;
  assign TX_BUSY = r_busy;
  assign TX_END  = r_end;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized checks of uart_tx against a frame-level
// reference model. The model holds the frame as a list of line levels
// {0, data MSB..LSB, 1}. It counts TXC ticks from acceptance and indexes that
// list by ticks/OVERSAMPLE. A line decoder rebuilds the word from the DUT's
// TXD by sampling mid-bit, the same way a receiver does.
// Cycle numbering: "cycle n+k" is the interval after clock edge n+k-1.
module tb_uart_tx;

  localparam int DATA_BITS   = 8;
  localparam int OVERSAMPLE  = 16;
  localparam int FRAME_BITS  = DATA_BITS + 2;
  localparam int FRAME_TICKS = FRAME_BITS * OVERSAMPLE;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 TXC;
  logic                 TX_START;
  logic [DATA_BITS-1:0] DQ;
  logic                 TXD;
  logic                 TX_BUSY;
  logic                 TX_END;

  uart_tx #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .TXC     (TXC),
    .TX_START(TX_START),
    .DQ      (DQ),
    .TXD     (TXD),
    .TX_BUSY (TX_BUSY),
    .TX_END  (TX_END)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit m_busy = 1'b0;
  bit m_end  = 1'b0;
  int m_ticks = 0;
  bit m_bits [FRAME_BITS];

  // Edge counter and observation bookkeeping.
  int cyc = 0;
  int acc_cyc = 0;
  int last_end_cyc = 0;
  int n_end = 0;
  int busy_cnt = 0;
  int low_cnt = 0;
  int txc_mode = 0;   // 0: every cycle, 1: every txc_div cycles, 2: random
  int txc_div = 1;

  logic                 line_q [$];
  logic [DATA_BITS-1:0] exp_q  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic next_txc();
    logic v;
    v = 1'b1;
    case (txc_mode)
      1: v = (((cyc + 1) % txc_div) == 0);
      2: v = ($urandom_range(0, 99) < 30);
      default: v = 1'b1;
    endcase
    return v;
  endfunction

  // Rebuilds the word from the ticked TXD samples of the frame that just
  // ended, sampling each bit at the middle of its period.
  task automatic decode_frame();
    int                   base;
    logic [DATA_BITS-1:0] got;
    logic [DATA_BITS-1:0] want;
    check("rx_samples", (line_q.size() >= FRAME_TICKS), 1);
    check("rx_pending", (exp_q.size() != 0), 1);
    if (line_q.size() >= FRAME_TICKS && exp_q.size() != 0) begin
      base = line_q.size() - FRAME_TICKS;
      got  = '0;
      for (int k = 0; k < DATA_BITS; k++) begin
        got[DATA_BITS-1-k] = line_q[base + (1 + k) * OVERSAMPLE + OVERSAMPLE / 2];
      end
      want = exp_q.pop_front();
      check("rx_start_bit", line_q[base + OVERSAMPLE / 2], 0);
      check("rx_stop_bit", line_q[base + (FRAME_BITS - 1) * OVERSAMPLE + OVERSAMPLE / 2], 1);
      check("rx_word", got, want);
    end
    line_q.delete();
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare all outputs 1 time unit later.
  task automatic tick();
    logic                 txc_s;
    logic                 st_s;
    logic                 line_s;
    logic [DATA_BITS-1:0] dq_s;
    logic                 exp_txd;
    txc_s  = TXC;
    st_s   = TX_START;
    dq_s   = DQ;
    line_s = TXD;
    @(posedge clk);
    cyc++;
    m_end = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      line_q.delete();
      exp_q.delete();
    end else if (!m_busy) begin
      if (st_s) begin
        m_busy  = 1'b1;
        m_ticks = 0;
        m_bits[0] = 1'b0;
        for (int k = 0; k < DATA_BITS; k++) m_bits[1 + k] = dq_s[DATA_BITS-1-k];
        m_bits[FRAME_BITS-1] = 1'b1;
        exp_q.push_back(dq_s);
        acc_cyc = cyc;
        line_q.delete();
      end
    end else if (txc_s) begin
      line_q.push_back(line_s);
      m_ticks++;
      if (m_ticks == FRAME_TICKS) begin
        m_busy = 1'b0;
        m_end  = 1'b1;
      end
    end
    #1;
    exp_txd = m_busy ? m_bits[m_ticks / OVERSAMPLE] : 1'b1;
    check("txd", TXD, exp_txd);
    check("tx_busy", TX_BUSY, m_busy);
    check("tx_end", TX_END, m_end);
    if (TX_BUSY === 1'b1) busy_cnt++;
    if (TXD === 1'b0) low_cnt++;
    if (TX_END === 1'b1) begin
      n_end++;
      last_end_cyc = cyc;
      decode_frame();
    end
    TXC = next_txc();
  endtask

  task automatic send(input logic [DATA_BITS-1:0] d);
    TX_START = 1'b1;
    DQ       = d;
    tick();
    TX_START = 1'b0;
    DQ       = DATA_BITS'($urandom());  // must not disturb the frame in flight
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (m_busy && k < budget) begin
      tick();
      k++;
    end
    check(tag, m_busy, 0);
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k;
    k = 0;
    while (TX_END !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(tag, TX_END, 1);
  endtask

  initial begin
    int e0;
    int e1;
    logic [DATA_BITS-1:0] d;

    // Reset held with a pending request: the request must be ignored.
    rst      = 1'b1;
    TXC      = 1'b1;
    TX_START = 1'b1;
    DQ       = 8'hA5;
    repeat (3) tick();
    TX_START = 1'b0;
    #2;
    rst = 1'b0;
    repeat (3) tick();
    check("idle_no_end", n_end, 0);

    // Single frame 8'hA5, TXC every cycle: TX_END in cycle n+161 (edge n+160).
    send(8'hA5);
    wait_done("a5_done", 400);
    check("a5_end_latency", last_end_cyc - acc_cyc, FRAME_TICKS);
    check("a5_end_count", n_end, 1);
    repeat (4) tick();

    // Slow tick (every 4th cycle), DQ=8'h00, acceptance aligned to a tick.
    txc_mode = 1;
    txc_div  = 4;
    TXC      = next_txc();
    for (int k = 0; k < 8 && TXC !== 1'b1; k++) tick();
    busy_cnt = 0;
    low_cnt  = 0;
    send(8'h00);
    wait_done("slow_done", 2000);
    check("slow_busy_cycles", busy_cnt, 640);
    check("slow_low_cycles", low_cnt, 9 * 64);
    txc_mode = 0;
    TXC      = 1'b1;
    repeat (3) tick();

    // Request with 8'hFF at cycle n+50 of an 8'h3C frame is ignored.
    e0 = n_end;
    send(8'h3C);
    repeat (49) tick();
    TX_START = 1'b1;
    DQ       = 8'hFF;
    tick();
    TX_START = 1'b0;
    wait_done("busy_req_done", 400);
    repeat (5) tick();
    check("busy_req_one_end", n_end - e0, 1);

    // Back-to-back: 8'h81, then 8'h7E requested in the TX_END cycle.
    send(8'h81);
    wait_end("b2b_first_end", 400);
    e1       = cyc;
    TX_START = 1'b1;
    DQ       = 8'h7E;
    tick();
    TX_START = 1'b0;
    check("b2b_second_start_txd", TXD, 0);
    wait_end("b2b_second_end", 400);
    check("b2b_end_spacing", cyc - e1, FRAME_TICKS + 1);
    repeat (3) tick();

    // Reset during data bit 3 of 8'hC3 (cycle n+88), asserted mid-cycle.
    e0 = n_end;
    send(8'hC3);
    repeat (87) tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_txd", TXD, 1);
    check("rst_async_busy", TX_BUSY, 0);
    check("rst_async_end", TX_END, 0);
    repeat (3) tick();
    #2;
    rst = 1'b0;
    repeat (3) tick();
    check("rst_no_end", n_end - e0, 0);
    send(8'h5A);
    wait_done("after_rst_done", 400);
    check("after_rst_end", n_end - e0, 1);

    // Random words under a random TXC with stray requests while busy.
    txc_mode = 2;
    for (int f = 0; f < 6; f++) begin
      int k;
      repeat ($urandom_range(0, 3)) tick();
      d = DATA_BITS'($urandom());
      send(d);
      k = 0;
      while (m_busy && k < 3000) begin
        TX_START = ($urandom_range(0, 49) == 0);
        DQ       = DATA_BITS'($urandom());
        tick();
        k++;
      end
      TX_START = 1'b0;
      check("rand_done", m_busy, 0);
    end
    repeat (4) tick();
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
